task_graph_scheduler: RTL and testbench
=======================================

# task_graph_scheduler

Arbitrates up to `NUM_APP` pending application mapping requests round-robin. Streams the granted application's `NUM_V`×`NUM_V` task-graph adjacency matrix from a shared graph memory into `task_mapper`. Per application it generates the `task_array`/`row`/`col` stream, the `root_task` marker and the `app_end` pulse that `task_mapper` consumes. It sits between the application request sources plus graph memory and the `task_mapper` input port.

## Interface
- `NUM_V`, 4, vertices per application graph; matrix is `NUM_V`×`NUM_V`, power of 2.
- `NUM_APP`, 4, number of requesters / graphs in memory, power of 2.
- `W`, 32, edge-weight width.
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `app_req` in `NUM_APP`: level request per application; sampled only in ARB.
- `app_grant` out `NUM_APP`: one-hot, 1-cycle pulse when the application is selected.
- `app_done` out `NUM_APP`: one-hot, 1-cycle pulse coincident with `app_end`.
- `mem_rd_en` out 1: graph memory read strobe.
- `mem_addr` out `clog2(NUM_APP)+2*clog2(NUM_V)`: `{app, row, col}`.
- `mem_rd_data` in `W`: read data, valid the cycle after `mem_rd_en`.
- `task_array` out `W`: current edge weight to `task_mapper`.
- `row`, `col` out `clog2(NUM_V)` each: indices of the current entry.
- `root_task` out 1: high while the first nonzero entry of the application is presented.
- `app_end` out 1: 1-cycle pulse after the last entry.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ARB, STREAM, END, GAP.
- IDLE → ARB when any `app_req` is high.
- ARB: the round-robin pick starts at `ptr`.
  - Pulse `app_grant[g]`.
  - Issue a read of `(g,0,0)`.
  - Set `ptr` to `g+1` mod `NUM_APP`.
  - Go to STREAM.
  - If no request is high, return to IDLE.
- STREAM: entries are presented in row-major order, `k = row*NUM_V + col`. Each entry is held exactly 2 cycles.
  - The read for entry k+1 is issued in the first presentation cycle of entry k, so there are no bubbles.
- `root_task` is high for both cycles of the first entry with `mem_rd_data != 0`, and never again within that application.
  - An all-zero graph never raises `root_task`.
- After the last entry (`NUM_V-1`, `NUM_V-1`), go to END.
  - END drives `app_end = 1` and `app_done[g] = 1`, with `task_array`, `row`, `col` = 0.
- GAP: one cycle with all stream outputs 0, then ARB.
- Idle values outside STREAM: `task_array = 0`, `row = col = 0`, `root_task = 0`.
- A request held high after service is re-served only after the other pending requesters (fairness).
- A request that drops while its application is streaming has no effect. The stream completes.
- `mem_rd_data` is registered before it drives `task_array`. No combinational path from memory to outputs.

## Timing
- Reset value of every output is 0: grant, done, `mem_rd_en`, `mem_addr`, `task_array`, `row`, `col`, `root_task`, `app_end`, `busy`.
  - `ptr` resets to 0 and the FSM to IDLE.
- Grant in cycle G: entry k is visible in cycles G+2+2k and G+3+2k.
  - With `NUM_V=4`, the last entry is at G+32 and G+33.
  - `app_end` at G+34, GAP at G+35, next `app_grant` at G+36 at the earliest.
- `mem_rd_en` is high in G and in G+2+2k for k = 0..`NUM_V²`-2. It is low otherwise.
- Reset mid-stream clears everything immediately, with no `app_end`/`app_done` emitted. The interrupted application must re-request.
- Simultaneous requests in ARB: the lowest index at or after `ptr` (with wrap) wins. Exactly one grant.

## Structure
- Package `task_map_pkg`:
  - FSM state enum.
  - Default `NUM_V`/`W`.
  - Address-pack function `{app,row,col}`.
- Sub-module `rr_arbiter`: `NUM_APP` requests, pointer input, one-hot grant out. Combinational pick; registered pointer lives in the parent.
- The entry counter (`clog2(NUM_V²)` bits) and the hold-phase bit live in the parent.

## Test plan
- Single request, memory graph for app 0 with M[0][1]=M[1][0]=5, M[1][2]=M[2][1]=6, M[0][3]=M[3][0]=7, others 0:
  - `app_grant[0]` at G.
  - `task_array` = 0,5,0,7,5,0,6,0,0,6,0,0,7,0,0,0, each held 2 cycles from G+2.
  - `root_task` high only at G+4 and G+5 (row 0, col 1).
  - `app_end` at G+34.
- All-zero graph for app 2:
  - 16 zero entries, `root_task` never high.
  - `app_end` and `app_done[2]` at G+34.
- `app_req` = 4'b1111 held from reset:
  - Grants in order 0,1,2,3,0 with grant spacing exactly 36 cycles.
  - Exactly one `app_end` per grant.
- `rst_b` low at G+10:
  - All outputs 0 within the same cycle, no `app_end`.
  - After release, `ptr` is 0 and a pending `app_req[1]` is granted at the first ARB.
- Requester 3 re-asserts immediately after done while requester 1 is pending: grant goes to 1 before 3.
- Check `mem_addr` against `{app,row,col}` for every `mem_rd_en` cycle, and that `mem_rd_en` never asserts in END or GAP.

Source files
------------

// File: rtl/task_map_pkg.sv
// Shared types and helpers for the task-graph scheduler: FSM state encoding,
// default geometry and the {app,row,col} graph-memory address packing.
package task_map_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_STREAM,
        S_END,
        S_GAP
    } state_t;

    localparam int DEF_NUM_V   = 4;
    localparam int DEF_NUM_APP = 4;
    localparam int DEF_W       = 32;

    // vb is the bit width of one matrix index; the caller truncates to its address width.
    function automatic logic [31:0] pack_addr(input logic [31:0] app,
                                              input logic [31:0] row,
                                              input logic [31:0] col,
                                              input int          vb);
        return (app << (2 * vb)) | (row << vb) | col;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// i_ptr (wrapping) wins; the pointer register is owned by the parent.
module rr_arbiter
    import task_map_pkg::*;
#(
    parameter  int NUM_APP = DEF_NUM_APP,
    localparam int AB      = $clog2(NUM_APP)
) (
    input  logic [NUM_APP-1:0] i_req,
    input  logic [AB-1:0]      i_ptr,
    output logic [NUM_APP-1:0] o_grant
);

    logic [AB-1:0] w_idx;
    logic          w_found;

    // Index arithmetic wraps naturally because NUM_APP is a power of two.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_APP; i++) begin
            w_idx = i_ptr + AB'(i);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/task_graph_scheduler.sv
// Round-robin scheduler that streams each granted application's adjacency
// matrix from graph memory into task_mapper, two cycles per entry.
module task_graph_scheduler
    import task_map_pkg::*;
#(
    parameter  int NUM_V   = DEF_NUM_V,
    parameter  int NUM_APP = DEF_NUM_APP,
    parameter  int W       = DEF_W,
    localparam int VB      = $clog2(NUM_V),
    localparam int AB      = $clog2(NUM_APP),
    localparam int KW      = 2 * VB,
    localparam int MAW     = AB + KW
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NUM_APP-1:0] app_req,
    output logic [NUM_APP-1:0] app_grant,
    output logic [NUM_APP-1:0] app_done,
    output logic               mem_rd_en,
    output logic [MAW-1:0]     mem_addr,
    input  logic [W-1:0]       mem_rd_data,
    output logic [W-1:0]       task_array,
    output logic [VB-1:0]      row,
    output logic [VB-1:0]      col,
    output logic               root_task,
    output logic               app_end,
    output logic               busy
);

    localparam logic [KW-1:0] K_LAST = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AB-1:0]      r_ptr;
    logic [AB-1:0]      r_app;
    logic [KW-1:0]      r_k;
    logic               r_ph;
    logic               r_pre;
    logic               r_seen;
    logic               r_root;
    logic [W-1:0]       r_data;

    logic [NUM_APP-1:0] w_gnt;
    logic [AB-1:0]      w_gidx;
    logic [KW-1:0]      w_k1;
    logic               w_any;
    logic               w_cap;

    assign w_any = |app_req;
    assign w_k1  = r_k + 1'b1;

    rr_arbiter #(
        .NUM_APP (NUM_APP)
    ) u_arb (
        .i_req   (app_req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt)
    );

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_APP; i++) begin
            if (w_gnt[i]) w_gidx = AB'(i);
        end
    end

    // Entry k is shown for two cycles; its successor is read in the first of
    // them and captured in the second, so the stream has no bubbles.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        app_grant   = '0;
        app_done    = '0;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        task_array  = '0;
        row         = '0;
        col         = '0;
        root_task   = 1'b0;
        app_end     = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (w_any) begin
                    app_grant   = w_gnt;
                    mem_rd_en   = 1'b1;
                    mem_addr    = MAW'(pack_addr(32'(w_gidx), 32'd0, 32'd0, VB));
                    w_state_nxt = S_STREAM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STREAM: begin
                if (r_pre) begin
                    w_cap = 1'b1;
                end else begin
                    task_array = r_data;
                    row        = r_k[KW-1:VB];
                    col        = r_k[VB-1:0];
                    root_task  = r_root;
                    if (!r_ph) begin
                        if (r_k != K_LAST) begin
                            mem_rd_en = 1'b1;
                            mem_addr  = MAW'(pack_addr(32'(r_app), 32'(w_k1[KW-1:VB]),
                                                       32'(w_k1[VB-1:0]), VB));
                        end
                    end else if (r_k != K_LAST) begin
                        w_cap = 1'b1;
                    end else begin
                        w_state_nxt = S_END;
                    end
                end
            end
            S_END: begin
                app_end         = 1'b1;
                app_done[r_app] = 1'b1;
                w_state_nxt     = S_GAP;
            end
            S_GAP: begin
                w_state_nxt = S_ARB;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_app   <= '0;
            r_k     <= '0;
            r_ph    <= 1'b0;
            r_pre   <= 1'b0;
            r_seen  <= 1'b0;
            r_root  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_ARB && w_any) begin
                r_ptr  <= w_gidx + 1'b1;
                r_app  <= w_gidx;
                r_k    <= '0;
                r_ph   <= 1'b0;
                r_pre  <= 1'b1;
                r_seen <= 1'b0;
            end
            if (r_state == S_STREAM) begin
                if (r_pre) begin
                    r_pre <= 1'b0;
                end else if (r_ph) begin
                    r_ph <= 1'b0;
                    r_k  <= w_k1;
                end else begin
                    r_ph <= 1'b1;
                end
            end
            // Root marks only the first nonzero weight of the application.
            if (w_cap) begin
                r_root <= (mem_rd_data != '0) && !r_seen;
                r_seen <= r_seen | (mem_rd_data != '0);
            end
        end
    end

    // Weight register is never visible outside STREAM, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_cap) r_data <= mem_rd_data;
    end

endmodule

// File: tb/tb_task_graph_scheduler.sv
// Scoreboard bench for task_graph_scheduler: stimulus queues expected grants,
// a negedge monitor checks every cycle of each serviced application.
module tb_task_graph_scheduler;

    logic        clk;
    logic        rst_b;
    logic [3:0]  app_req;
    logic [3:0]  app_grant;
    logic [3:0]  app_done;
    logic        mem_rd_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic [31:0] task_array;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        root_task;
    logic        app_end;
    logic        busy;

    task_graph_scheduler dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .app_req     (app_req),
        .app_grant   (app_grant),
        .app_done    (app_done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .task_array  (task_array),
        .row         (row),
        .col         (col),
        .root_task   (root_task),
        .app_end     (app_end),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Graph memory with one cycle of read latency.
    logic [31:0] gmem [0:63];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= gmem[mem_addr];
    end

    function automatic int maddr(input int a, input int r, input int c);
        return a * 16 + r * 4 + c;
    endfunction

    // Hand-derived row-major weight sequences and root entry per application.
    int tab [4][16] = '{
        '{0, 5, 0, 7, 5, 0, 6, 0, 0, 6, 0, 0, 7, 0, 0, 0},
        '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16},
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0}
    };
    int root_tab [4] = '{1, 0, -1, 14};

    typedef struct {
        int app;
        int gap;
    } rec_t;

    rec_t sb[$];
    rec_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   in_flight = 0;
    bit   gap_pend = 0;
    int   g_cyc = 0;
    int   last_g = 0;
    int   off;
    int   k;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_grant(input int app, input int gap);
        rec_t r;
        r.app = app;
        r.gap = gap;
        sb.push_back(r);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_b) begin
            in_flight = 0;
            gap_pend  = 0;
            chk("reset_outs", 64'({app_grant, app_done, mem_rd_en, mem_addr, task_array,
                                   row, col, root_task, app_end, busy}), 64'd0);
        end else begin
            if (app_grant != 4'b0) begin
                if (in_flight || sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant @cyc %0d: got %b, expected none", cyc, app_grant);
                end else begin
                    cur       = sb.pop_front();
                    in_flight = 1;
                    gap_pend  = 0;
                    g_cyc     = cyc;
                    chk("grant_vec", 64'(app_grant), 64'd1 << cur.app);
                    if (cur.gap >= 0) chk("grant_spacing", 64'(cyc - last_g), 64'(cur.gap));
                    last_g = cyc;
                end
            end
            if (in_flight) begin
                off = cyc - g_cyc;
                if (off == 0) begin
                    chk("arb_rd_en", 64'(mem_rd_en), 64'd1);
                    chk("arb_addr", 64'(mem_addr), 64'(maddr(cur.app, 0, 0)));
                    chk("arb_task", 64'(task_array), 64'd0);
                    chk("arb_busy", 64'(busy), 64'd1);
                end else if (off == 1) begin
                    chk("fill_quiet", 64'({mem_rd_en, task_array, root_task, app_end}), 64'd0);
                end else if (off <= 33) begin
                    k = (off - 2) / 2;
                    chk("task_array", 64'(task_array), 64'(tab[cur.app][k]));
                    chk("row", 64'(row), 64'(k / 4));
                    chk("col", 64'(col), 64'(k % 4));
                    chk("root_task", 64'(root_task), (k == root_tab[cur.app]) ? 64'd1 : 64'd0);
                    chk("stream_end_quiet", 64'({app_end, app_done}), 64'd0);
                    if ((off % 2) == 0 && k <= 14) begin
                        chk("stream_rd_en", 64'(mem_rd_en), 64'd1);
                        chk("stream_addr", 64'(mem_addr), 64'(maddr(cur.app, (k + 1) / 4, (k + 1) % 4)));
                    end else begin
                        chk("stream_rd_idle", 64'(mem_rd_en), 64'd0);
                    end
                end else begin
                    chk("app_end", 64'(app_end), 64'd1);
                    chk("app_done", 64'(app_done), 64'd1 << cur.app);
                    chk("end_outs", 64'({mem_rd_en, task_array, row, col, root_task}), 64'd0);
                    in_flight = 0;
                    gap_pend  = 1;
                end
            end else if (gap_pend) begin
                gap_pend = 0;
                chk("gap_outs", 64'({app_grant, app_done, mem_rd_en, task_array, row, col,
                                     root_task, app_end}), 64'd0);
                chk("gap_busy", 64'(busy), 64'd1);
            end else begin
                chk("idle_outs", 64'({app_done, mem_rd_en, task_array, row, col,
                                      root_task, app_end}), 64'd0);
            end
        end
    end

    task automatic wait_grant(input int app);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (app_grant[app]) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_grant: no grant for app %0d within 300 cycles, expected one", app);
        end
    endtask

    task automatic wait_done(input int app);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (app_done[app]) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: no app_done for app %0d within 300 cycles, expected one", app);
        end
    endtask

    task automatic step_set_req(input logic [3:0] v);
        @(posedge clk);
        #1 app_req = v;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b   = 1'b0;
        app_req = 4'b0;
        for (int i = 0; i < 64; i++) gmem[i] = 32'd0;
        gmem[maddr(0, 0, 1)] = 32'd5;
        gmem[maddr(0, 1, 0)] = 32'd5;
        gmem[maddr(0, 1, 2)] = 32'd6;
        gmem[maddr(0, 2, 1)] = 32'd6;
        gmem[maddr(0, 0, 3)] = 32'd7;
        gmem[maddr(0, 3, 0)] = 32'd7;
        for (int i = 0; i < 16; i++) gmem[16 + i] = 32'(i + 1);
        gmem[maddr(3, 3, 2)] = 32'd9;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;

        // Single request, sparse symmetric graph for app 0.
        expect_grant(0, -1);
        step_set_req(4'b0001);
        wait_grant(0);
        step_set_req(4'b0000);
        wait_done(0);
        repeat (4) @(posedge clk);

        // All-zero graph for app 2.
        expect_grant(2, -1);
        step_set_req(4'b0100);
        wait_grant(2);
        step_set_req(4'b0000);
        wait_done(2);
        repeat (4) @(posedge clk);

        // Every requester held from reset: strict rotation, 36-cycle spacing.
        #1 rst_b = 1'b0;
        app_req = 4'b1111;
        expect_grant(0, -1);
        expect_grant(1, 36);
        expect_grant(2, 36);
        expect_grant(3, 36);
        expect_grant(0, 36);
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        wait_grant(0);
        wait_grant(1);
        wait_grant(2);
        wait_grant(3);
        wait_grant(0);
        step_set_req(4'b0000);
        wait_done(0);
        repeat (4) @(posedge clk);

        // Reset mid-stream: app 1 interrupted, pointer back to 0 so 1 beats 3.
        expect_grant(1, -1);
        step_set_req(4'b0010);
        wait_grant(1);
        repeat (10) @(posedge clk);
        #1 rst_b = 1'b0;
        app_req = 4'b1010;
        expect_grant(1, -1);
        expect_grant(3, 36);
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        wait_grant(1);
        step_set_req(4'b1000);
        wait_grant(3);
        step_set_req(4'b0000);
        wait_done(3);
        repeat (4) @(posedge clk);

        // Fairness: 3 re-requests right after its done while 1 waits.
        expect_grant(3, -1);
        expect_grant(1, 36);
        expect_grant(3, 36);
        step_set_req(4'b1000);
        wait_grant(3);
        step_set_req(4'b0010);
        wait_done(3);
        step_set_req(4'b1010);
        wait_grant(1);
        step_set_req(4'b1000);
        wait_grant(3);
        step_set_req(4'b0000);
        wait_done(3);
        repeat (6) @(posedge clk);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
